inst_fetch_responder: RTL and testbench

//  Memory-side responder for the IF stage's fetch handshake. Accepts one PC per request, serves it from a

---
 rtl/inst_fetch_responder.sv | 157 +++++++++++++++
 tb/tb_inst_fetch_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for the IF fetch handshake: serves a PC from a direct-mapped
// I-cache, or assembles the 4-byte instruction over the byte-wide RAM port on a miss.
module inst_fetch_responder #(
    parameter int ADDR_W       = 17,
    parameter int ICACHE_LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [31:0]       pc_req,
    input  logic              branch_interception,
    input  logic              icache_inv,
    input  logic              dport_req,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_din,
    output logic              addr_needed,
    output logic [1:0]        memcnf,
    output logic              inst_available,
    output logic [31:0]       inst_out,
    output logic [31:0]       pc_back,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_a
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, RESP} state_t;

    state_t state, state_nxt;

    logic [31:0]             pc_q;
    logic [31:0]             word_q;
    logic [31:0]             inst_q;
    logic [31:0]             pc_back_q;
    logic [2:0]              issue_cnt;
    logic [2:0]              recv_cnt;
    logic                    pend;
    logic [1:0]              pend_idx;
    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             accept;
    logic             issue;
    logic             pulse;
    logic             fill;
    logic [31:0]      pulse_word;

    assign idx = pc_q[IDX_W+1:2];
    assign tag = pc_q[ADDR_W-1:IDX_W+2];
    assign hit = valid_q[idx] && (tag_mem[idx] == tag);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_nxt  = state;
        mem_req    = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        pulse      = 1'b0;
        fill       = 1'b0;
        pulse_word = word_q;
        case (state)
            IDLE: begin
                // memcnf[0] is always 0 in IDLE, so only the data-port conflict gates acceptance
                accept = rst && req_valid && !dport_req && !branch_interception;
                if (accept) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (branch_interception) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    pulse      = 1'b1;
                    pulse_word = data_mem[idx];
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (branch_interception) begin
                    state_nxt = IDLE;
                end else begin
                    mem_req = !issue_cnt[2];
                    issue   = mem_req && mem_gnt;
                    if (pend && recv_cnt == 3'd3) state_nxt = RESP;
                end
            end
            RESP: begin
                pulse     = !branch_interception;
                fill      = !branch_interception;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign addr_needed    = rst && (state == IDLE);
    assign memcnf         = rst ? {dport_req, mem_req && !mem_gnt} : 2'b00;
    assign mem_a          = mem_req ? pc_q[ADDR_W-1:0] + ADDR_W'(issue_cnt) : '0;
    assign inst_available = pulse;
    assign inst_out       = pulse ? pulse_word : inst_q;
    assign pc_back        = pulse ? pc_q : pc_back_q;

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc_q      <= '0;
            word_q    <= '0;
            inst_q    <= '0;
            pc_back_q <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend      <= 1'b0;
            pend_idx  <= '0;
            valid_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) pc_q <= pc_req;
            if (state == LOOKUP) begin
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
            if (state == FETCH) begin
                // the byte granted this cycle arrives on mem_din next cycle; a flush clears pend
                pend     <= issue;
                pend_idx <= issue_cnt[1:0];
                if (issue) issue_cnt <= issue_cnt + 3'd1;
                if (pend && !branch_interception) begin
                    word_q[8*pend_idx +: 8] <= mem_din;
                    recv_cnt                <= recv_cnt + 3'd1;
                end
            end else begin
                pend <= 1'b0;
            end
            if (pulse) begin
                inst_q    <= pulse_word;
                pc_back_q <= pc_q;
            end
            if (icache_inv) valid_q <= '0;
            else if (fill) valid_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are deliberately not reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= word_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: directed vector table, multi-cycle corner
// sequences and randomized fetches checked against a line-level cache/RAM model.
module tb_inst_fetch_responder;

    localparam int ADDR_W = 17;
    localparam int LINES  = 64;
    localparam int RAM_SZ = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic [31:0]       pc_req = '0;
    logic              branch_interception = 1'b0;
    logic              icache_inv = 1'b0;
    logic              dport_req = 1'b0;
    logic              mem_gnt = 1'b0;
    logic [7:0]        mem_din = '0;
    logic              addr_needed;
    logic [1:0]        memcnf;
    logic              inst_available;
    logic [31:0]       inst_out;
    logic [31:0]       pc_back;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_a;

    inst_fetch_responder #(.ADDR_W(ADDR_W), .ICACHE_LINES(LINES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .pc_req              (pc_req),
        .branch_interception (branch_interception),
        .icache_inv          (icache_inv),
        .dport_req           (dport_req),
        .mem_gnt             (mem_gnt),
        .mem_din             (mem_din),
        .addr_needed         (addr_needed),
        .memcnf              (memcnf),
        .inst_available      (inst_available),
        .inst_out            (inst_out),
        .pc_back             (pc_back),
        .mem_req             (mem_req),
        .mem_a               (mem_a)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // RAM and arbiter model: grant policy by gnt_mode, read data one cycle after a granted address
    logic [7:0]        ram [RAM_SZ];
    int                gnt_mode = 0;
    bit                alt_phase = 1'b0;
    bit                issued = 1'b0;
    logic [ADDR_W-1:0] iss_addr = '0;

    always @(negedge clk) begin
        issued   = mem_req && mem_gnt;
        iss_addr = mem_a;
    end

    always @(posedge clk) begin
        #1;
        mem_din   = issued ? ram[iss_addr] : 8'($urandom);
        alt_phase = ~alt_phase;
        case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = alt_phase;
            2:       mem_gnt = 1'($urandom_range(0, 1));
            default: mem_gnt = 1'b0;
        endcase
    end

    // Cache model: one entry per index remembering which word line (pc[16:2]) it holds
    bit          m_valid [LINES];
    logic [14:0] m_line  [LINES];

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[pc[7:2]] && (m_line[pc[7:2]] == pc[16:2]);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] pc);
        logic [ADDR_W-1:0] a;
        a = pc[ADDR_W-1:0];
        return {ram[a + ADDR_W'(3)], ram[a + ADDR_W'(2)], ram[a + ADDR_W'(1)], ram[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch from IDLE; inv_at>0 raises icache_inv during that cycle after acceptance
    task automatic do_fetch(input logic [31:0] pc, input bit exp_hit, input logic [31:0] exp_word,
                            input int exp_lat, input int inv_at);
        int cyc;
        int n_issued;
        bit seen_req;
        bit done;
        tick();
        req_valid = 1'b1;
        pc_req    = pc;
        @(negedge clk);
        check("accept_ready", {29'd0, addr_needed, memcnf}, 32'h4);
        tick();
        req_valid = 1'b0;
        cyc       = 1;
        n_issued  = 0;
        seen_req  = 1'b0;
        done      = 1'b0;
        while (!done && cyc <= 100) begin
            if (inv_at == cyc) icache_inv = 1'b1;
            @(negedge clk);
            if (inst_available) begin
                done = 1'b1;
            end else begin
                if (mem_req) begin
                    seen_req = 1'b1;
                    check("memcnf_fetch", {30'd0, memcnf}, {30'd0, 1'b0, !mem_gnt});
                    if (mem_gnt) begin
                        check("mem_a", {15'd0, mem_a}, {15'd0, ADDR_W'(pc[ADDR_W-1:0] + n_issued)});
                        n_issued++;
                    end
                end else begin
                    check("memcnf_quiet", {30'd0, memcnf}, 32'd0);
                end
                tick();
                icache_inv = 1'b0;
                cyc++;
            end
        end
        check("pulse_seen", {31'd0, done}, 32'd1);
        if (done) begin
            check("inst_out", inst_out, exp_word);
            check("pc_back", pc_back, pc);
            check("mem_used", {31'd0, seen_req}, {31'd0, !exp_hit});
            check("bytes_issued", n_issued, exp_hit ? 0 : 4);
            if (exp_lat > 0) check("latency", cyc, exp_lat);
        end
        if (inv_at > 0) model_clear();
        if (!exp_hit && inv_at != cyc) begin
            m_valid[pc[7:2]] = 1'b1;
            m_line[pc[7:2]]  = pc[16:2];
        end
        tick();
        icache_inv = 1'b0;
        @(negedge clk);
        check("pulse_single", {31'd0, inst_available}, 32'd0);
        check("inst_hold", inst_out, exp_word);
        check("back_to_idle", {31'd0, addr_needed}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] pc;
        int          mode;
        bit          hit;
        logic [31:0] word;
        int          lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        vecs[0] = '{pc: 32'h0000_0000, mode: 0, hit: 1'b0, word: 32'h0000_0513, lat: 7};
        vecs[1] = '{pc: 32'h0000_0000, mode: 0, hit: 1'b1, word: 32'h0000_0513, lat: 1};
        vecs[2] = '{pc: 32'h0000_0100, mode: 1, hit: 1'b0, word: 32'h0010_0093, lat: 0};
        vecs[3] = '{pc: 32'h0000_0100, mode: 0, hit: 1'b1, word: 32'h0010_0093, lat: 1};

        for (int i = 0; i < RAM_SZ; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
        ram[32'h100] = 8'h93; ram[32'h101] = 8'h00; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        model_clear();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_needed", {31'd0, addr_needed}, 32'd0);
        check("rst_outputs", {28'd0, memcnf, inst_available, mem_req}, 32'd0);
        check("rst_inst_out", inst_out, 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("first_idle", {31'd0, addr_needed}, 32'd1);

        // directed table: cold miss, hit, grant gaps, hit again
        for (int v = 0; v < 4; v++) begin
            gnt_mode = vecs[v].mode;
            do_fetch(vecs[v].pc, vecs[v].hit, vecs[v].word, vecs[v].lat, 0);
        end
        gnt_mode = 0;

        // invalidate in IDLE, then the former hit must miss
        tick();
        icache_inv = 1'b1;
        tick();
        icache_inv = 1'b0;
        model_clear();
        do_fetch(32'h0, 1'b0, 32'h0000_0513, 7, 0);

        // invalidate on the RESP edge beats the fill
        do_fetch(32'h40, 1'b0, ram_word(32'h40), 7, 7);
        do_fetch(32'h40, 1'b0, ram_word(32'h40), 7, 0);

        // data-port conflict and same-cycle interception both leave the request unaccepted
        tick();
        dport_req = 1'b1;
        req_valid = 1'b1;
        pc_req    = 32'h200;
        @(negedge clk);
        check("conflict_memcnf", {30'd0, memcnf}, 32'd2);
        tick();
        dport_req           = 1'b0;
        branch_interception = 1'b1;
        @(negedge clk);
        check("conflict_still_idle", {30'd0, addr_needed, mem_req}, 32'd2);
        check("flush_req_memcnf", {30'd0, memcnf}, 32'd0);
        tick();
        branch_interception = 1'b0;
        req_valid           = 1'b0;
        @(negedge clk);
        check("flush_req_ignored", {30'd0, addr_needed, inst_available}, 32'd2);

        // flush after two bytes issued: no pulse, no fill
        tick();
        icache_inv = 1'b1;
        tick();
        icache_inv = 1'b0;
        model_clear();
        req_valid = 1'b1;
        pc_req    = 32'h100;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        branch_interception = 1'b1;
        @(negedge clk);
        check("flush_no_pulse", {30'd0, inst_available, mem_req}, 32'd0);
        tick();
        branch_interception = 1'b0;
        @(negedge clk);
        check("flush_idle", {31'd0, addr_needed}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (inst_available) pulses++;
        end
        check("flush_quiet", pulses, 0);
        do_fetch(32'h100, 1'b0, 32'h0010_0093, 7, 0);

        // randomized fetches against the model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] pc;
            bit          h;
            pc       = $urandom;
            pc[16:8] = ($urandom_range(0, 1) != 0) ? 9'h0A5 : 9'h15A;
            pc[7:2]  = 6'($urandom_range(0, 7));
            pc[1:0]  = 2'b00;
            gnt_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
            h        = model_hit(pc);
            do_fetch(pc, h, ram_word(pc), h ? 1 : (gnt_mode == 0 ? 7 : 0), 0);
        end
        gnt_mode = 0;

        // reset mid-FETCH together with icache_inv, then the former hit misses
        do_fetch(32'h0, model_hit(32'h0), 32'h0000_0513, 0, 0);
        tick();
        req_valid = 1'b1;
        pc_req    = 32'h300;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst        = 1'b0;
        icache_inv = 1'b1;
        #1;
        check("async_rst_ctrl", {27'd0, addr_needed, memcnf, inst_available, mem_req}, 32'd0);
        check("async_rst_inst", inst_out, 32'd0);
        check("async_rst_pc", pc_back, 32'd0);
        check("async_rst_addr", {15'd0, mem_a}, 32'd0);
        tick();
        rst        = 1'b1;
        icache_inv = 1'b0;
        model_clear();
        @(negedge clk);
        check("rst_release_idle", {31'd0, addr_needed}, 32'd1);
        do_fetch(32'h0, 1'b0, 32'h0000_0513, 7, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
